// File: rtl/h264_dequant_pkg.sv
// Shared definitions for the H.264 inverse quantiser.
//   - VA/VB/VC rescale tables, indexed by QP%6
//   - position class enum and the 4x4 index -> class mapping
//   - output saturation limits
package h264_dequant_pkg;

  typedef enum logic [1:0] {POS_A, POS_B, POS_C} pos_class_e;

  // Entries 6 and 7 are never selected (qm <= 5); they pad the table to a full 3-bit index.
  localparam logic [7:0][4:0] VA = {5'd0, 5'd0, 5'd18, 5'd16, 5'd14, 5'd13, 5'd11, 5'd10};
  localparam logic [7:0][4:0] VB = {5'd0, 5'd0, 5'd29, 5'd25, 5'd23, 5'd20, 5'd18, 5'd16};
  localparam logic [7:0][4:0] VC = {5'd0, 5'd0, 5'd23, 5'd20, 5'd18, 5'd16, 5'd14, 5'd13};

  localparam int WMAX = 32767;
  localparam int WMIN = -32768;

  function automatic pos_class_e pos_class(input logic [3:0] idx);
    pos_class_e pc;
    unique case (idx)
      4'd0, 4'd3, 4'd5, 4'd11:  pc = POS_A;
      4'd4, 4'd10, 4'd12, 4'd15: pc = POS_B;
      default:                   pc = POS_C;
    endcase
    return pc;
  endfunction

  function automatic logic [4:0] v_lookup(input pos_class_e pc, input logic [2:0] qm);
    logic [4:0] v;
    unique case (pc)
      POS_A:   v = VA[qm];
      POS_B:   v = VB[qm];
      default: v = VC[qm];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/h264_qp_divmod6.sv
// Combinational QP split for the inverse quantiser.
//   qp : quantiser parameter (values above 51 are treated as 51)
//   qd : qp / 6  (0..8)
//   qm : qp % 6  (0..5)
module h264_qp_divmod6 (
  input  logic [5:0] qp,
  output logic [3:0] qd,
  output logic [2:0] qm
);

  logic [5:0] rem;

  // Repeated subtraction; eight steps cover the clamped range 0..51.
  always_comb begin
    rem = (qp > 6'd51) ? 6'd51 : qp;
    qd  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (rem >= 6'd6) begin
        rem = rem - 6'd6;
        qd  = qd + 4'd1;
      end
    end
    qm = rem[2:0];
  end

endmodule

// File: rtl/h264_dequantise.sv
// H.264 inverse quantiser for the encoder reconstruction path.
// Rescales W = Z*V(QP%6,pos) << (QP/6), DC coefficients rounded (x+1)>>>1,
// saturated to 16 bits. Three-stage pipeline, one coefficient per cycle.
//   CLK, RESET  : clock, asynchronous active-high reset
//   ENABLE      : ZIN/DCCI valid this cycle
//   DCCI        : ZIN is a DC coefficient
//   QP          : quantiser parameter (latched per block)
//   ZIN         : signed quantised coefficient
//   VALID       : WOUT valid
//   DCCO        : DC flag aligned with WOUT
//   LAST        : WOUT is the index-0 AC coefficient of a 4x4 block
//   WOUT        : signed saturated rescaled coefficient (held when VALID=0)
module h264_dequantise
  import h264_dequant_pkg::*;
#(
  parameter int ZW = 12,
  parameter int WW = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 DCCI,
  input  logic [5:0]           QP,
  input  logic signed [ZW-1:0] ZIN,
  output logic                 VALID,
  output logic                 DCCO,
  output logic                 LAST,
  output logic signed [WW-1:0] WOUT
);

  localparam int PW = ZW + 6;  // product width
  localparam int SW = PW + 8;  // product shifted by up to 8

  logic [3:0]  idx;
  logic [5:0]  qp_lat;
  logic        first;
  logic [5:0]  qp_eff;
  logic [3:0]  qd;
  logic [2:0]  qm;
  logic [4:0]  v_sel;

  // The coefficient that captures QP must already use the new value.
  assign first  = ENABLE && (DCCI || idx == 4'd15);
  assign qp_eff = first ? QP : qp_lat;

  h264_qp_divmod6 u_divmod (
    .qp (qp_eff),
    .qd (qd),
    .qm (qm)
  );

  assign v_sel = v_lookup(DCCI ? POS_A : pos_class(idx), qm);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx    <= 4'd15;
      qp_lat <= '0;
    end else begin
      // Natural 4-bit wrap gives 0 -> 15.
      if (!ENABLE || DCCI) idx <= 4'd15;
      else                 idx <= idx - 4'd1;
      if (first) qp_lat <= QP;
    end
  end

  // S1
  logic                 s1_vld, s1_dc, s1_last;
  logic signed [ZW-1:0] s1_z;
  logic [4:0]           s1_v;
  logic [3:0]           s1_qd;
  // S2
  logic                 s2_vld, s2_dc, s2_last;
  logic signed [PW-1:0] s2_prod;
  logic [3:0]           s2_qd;

  logic signed [PW-1:0] z_ext, v_ext;
  logic signed [SW-1:0] shifted, rounded;
  logic signed [WW-1:0] w_sat;

  always_comb begin
    z_ext = PW'(s1_z);
    v_ext = PW'({1'b0, s1_v});
  end

  always_comb begin
    shifted = SW'(s2_prod) <<< s2_qd;
    rounded = s2_dc ? ((shifted + SW'(1)) >>> 1) : shifted;
    if (rounded > SW'(WMAX))      w_sat = WW'(WMAX);
    else if (rounded < SW'(WMIN)) w_sat = WW'(WMIN);
    else                          w_sat = rounded[WW-1:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vld  <= 1'b0;
      s1_dc   <= 1'b0;
      s1_last <= 1'b0;
      s1_z    <= '0;
      s1_v    <= '0;
      s1_qd   <= '0;
      s2_vld  <= 1'b0;
      s2_dc   <= 1'b0;
      s2_last <= 1'b0;
      s2_prod <= '0;
      s2_qd   <= '0;
      VALID   <= 1'b0;
      DCCO    <= 1'b0;
      LAST    <= 1'b0;
      WOUT    <= '0;
    end else begin
      s1_vld  <= ENABLE;
      s1_dc   <= ENABLE && DCCI;
      s1_last <= ENABLE && !DCCI && (idx == 4'd0);
      s1_z    <= ZIN;
      s1_v    <= v_sel;
      s1_qd   <= qd;

      s2_vld  <= s1_vld;
      s2_dc   <= s1_dc;
      s2_last <= s1_last;
      s2_prod <= z_ext * v_ext;
      s2_qd   <= s1_qd;

      VALID   <= s2_vld;
      DCCO    <= s2_dc;
      LAST    <= s2_last;
      if (s2_vld) WOUT <= w_sat;
    end
  end

endmodule

// File: tb/tb_h264_dequantise.sv
module tb_h264_dequantise;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               ENABLE;
  logic               DCCI;
  logic [5:0]         QP;
  logic signed [11:0] ZIN;
  logic               VALID;
  logic               DCCO;
  logic               LAST;
  logic signed [15:0] WOUT;

  h264_dequantise #(.ZW(12), .WW(16)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .DCCI   (DCCI),
    .QP     (QP),
    .ZIN    (ZIN),
    .VALID  (VALID),
    .DCCO   (DCCO),
    .LAST   (LAST),
    .WOUT   (WOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int w;
    bit dc;
    bit last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_idx  = 15;
  int m_qp   = 0;
  int last_w = 0;
  int va[6] = '{10, 11, 13, 14, 16, 18};
  int vb[6] = '{16, 18, 20, 23, 25, 29};
  int vc[6] = '{13, 14, 16, 18, 20, 23};

  always @(posedge CLK) cyc++;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: ordering, QP latch and rescale taken from the block behaviour.
  task automatic model(input bit en, input bit dc, input int qp, input int z);
    int q, qd, qm, v;
    longint w;
    exp_t e;
    if (en) begin
      if (dc || m_idx == 15) m_qp = qp;
      q  = (m_qp > 51) ? 51 : m_qp;
      qd = q / 6;
      qm = q % 6;
      if (dc) v = va[qm];
      else begin
        case (m_idx)
          0, 3, 5, 11:   v = va[qm];
          4, 10, 12, 15: v = vb[qm];
          default:       v = vc[qm];
        endcase
      end
      w = longint'(z) * v * (longint'(1) << qd);
      if (dc) w = (w + 1) >>> 1;
      if (w > 32767)  w = 32767;
      if (w < -32768) w = -32768;
      e.w    = int'(w);
      e.dc   = dc;
      e.last = !dc && (m_idx == 0);
      e.cyc  = cyc;
      sb.push_back(e);
    end
    if (!en || dc)       m_idx = 15;
    else if (m_idx == 0) m_idx = 15;
    else                 m_idx = m_idx - 1;
  endtask

  task automatic drive(input bit en, input bit dc, input int qp, input int z);
    @(posedge CLK);
    #1;
    ENABLE = en;
    DCCI   = dc;
    QP     = qp[5:0];
    ZIN    = z[11:0];
    model(en, dc, qp, z);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      if (VALID) begin
        if (sb.size() == 0) check_val("spurious_valid", VALID, 0);
        else begin
          e = sb.pop_front();
          check_val("wout", WOUT, e.w);
          check_val("dcco", DCCO, e.dc);
          check_val("last", LAST, e.last);
          check_val("latency", cyc - e.cyc, 3);
          last_w = e.w;
        end
      end else begin
        check_val("wout_hold", WOUT, last_w);
        check_val("last_idle", LAST, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rz, r;
    RESET  = 1'b1;
    ENABLE = 1'b1;
    DCCI   = 1'b0;
    QP     = 6'd28;
    ZIN    = 12'sd5;
    repeat (4) begin
      @(negedge CLK);
      check_val("rst_valid", VALID, 0);
      check_val("rst_wout", WOUT, 0);
      check_val("rst_last", LAST, 0);
    end
    @(posedge CLK);
    #1;
    ENABLE = 1'b0;
    RESET  = 1'b0;
    idle(2);

    // QP=28: idx15 -> 400, idx14 -> 320, idx0 -> 256
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 28, 1);
    idle(2);

    // QP=0 full-scale negative; idx0 -> -20480
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 0, -2048);
    // QP=51 saturation both ways, back to back
    drive(1'b1, 1'b0, 51, 2047);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 51, -2047);
    // QP above 51 clamps
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 60, (i * 37) % 200 - 100);
    idle(2);

    // DC: QP=6, 3 -> 30, -3 -> -30, then AC restarts at idx 15
    drive(1'b1, 1'b1, 6, 3);
    drive(1'b1, 1'b1, 6, -3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 6, 5);
    idle(2);

    // QP change mid-block is ignored until the next block
    for (int i = 0; i < 8; i++)  drive(1'b1, 1'b0, 20, i - 3);
    for (int i = 0; i < 8; i++)  drive(1'b1, 1'b0, 40, i + 1);
    for (int i = 0; i < 4; i++)  drive(1'b1, 1'b0, 40, -i - 1);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 10, 7);
    idle(2);

    // ENABLE drop after 7 coefficients
    for (int i = 0; i < 7; i++)  drive(1'b1, 1'b0, 33, 9 - i);
    idle(3);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 33, 2 * i - 15);

    // DC interleaved mid-block
    for (int i = 0; i < 5; i++)  drive(1'b1, 1'b0, 17, 11 + i);
    drive(1'b1, 1'b1, 23, -100);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 17, -i);
    idle(2);

    // QP sweep with random residuals, random gaps, DC and mid-block QP noise
    for (int q = 0; q < 52; q++) begin
      for (int k = 0; k < 16; k++) begin
        rz = int'($urandom_range(0, 4095)) - 2048;
        r  = int'($urandom_range(0, 19));
        if (r == 0)      drive(1'b0, 1'b0, q, 0);
        else if (r == 1) drive(1'b1, 1'b1, q, rz);
        else             drive(1'b1, 1'b0, (k == 0) ? q : int'($urandom_range(0, 63)), rz);
      end
    end
    idle(5);

    // Reset with coefficients in flight
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 12, 100 + i);
    @(posedge CLK);
    #2;
    RESET  = 1'b1;
    ENABLE = 1'b0;
    sb.delete();
    m_idx  = 15;
    m_qp   = 0;
    last_w = 0;
    #1;
    check_val("rst_flush_valid", VALID, 0);
    check_val("rst_flush_wout", WOUT, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(6);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 45, 3 - i);
    idle(6);

    check_val("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
